i2s_adc_receiver: RTL and testbench

//  Receive-side I2S deserializer for the codec ADC path; counterpart of the DAC serializer that drives AUD_DACDAT.

---
 rtl/i2s_adc_receiver_if.sv | 12 +
 rtl/i2s_adc_receiver.sv | 188 ++++++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_adc_receiver_if.sv
// Consumer-side word handshake of the I2S ADC receiver: stereo word, valid/ready, full.
interface i2s_adc_receiver_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic [2*SAMPLE_WIDTH-1:0] ADCDATA;
  logic                      adc_valid;
  logic                      adc_ready;
  logic                      adc_full;

  modport master (output ADCDATA, output adc_valid, output adc_full, input adc_ready);
  modport slave  (input ADCDATA, input adc_valid, input adc_full, output adc_ready);
endinterface

// File: rtl/i2s_adc_receiver.sv
// I2S ADC deserializer: oversampled codec BCLK/LRCK/DAT -> {left,right} word with valid/ready.
// Define ADC_RX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module i2s_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               EN,
  input  logic               AUD_BCLK,
  input  logic               AUD_ADCLRCK,
  input  logic               AUD_ADCDAT,
  i2s_adc_receiver_if.master adc,
  output logic               data_over,
  output logic               frame_err,
  input  logic               clr_err
);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam int WW = 2 * SAMPLE_WIDTH;

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;
  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0]  bclk_sync, lrck_sync, dat_sync;
  logic                    bclk_prev, lrck_last;
  logic                    bclk_s, lrck_s, dat_s, bclk_rise, lr_change;
  logic [SAMPLE_WIDTH-1:0] left_sr, right_sr, left_nxt, right_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic                    frame_done, short_chan, pop, overflow;
  logic [WW-1:0]           frame_word;

  assign bclk_s    = bclk_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_s && !bclk_prev;
  // LRCK is compared only at BCLK rises, so the first rise after a change is the delay slot
  assign lr_change = lrck_s != lrck_last;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_prev <= 1'b0;
      lrck_last <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_prev <= bclk_s;
      if (bclk_rise) lrck_last <= lrck_s;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      left_sr  <= '0;
      right_sr <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      left_sr  <= left_nxt;
      right_sr <= right_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    left_nxt   = left_sr;
    right_nxt  = right_sr;
    frame_done = 1'b0;
    short_chan = 1'b0;
    if (!EN) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (bclk_rise) begin
      if (lr_change) begin
        cnt_nxt = '0;
        // A short channel keeps its received MSBs and is zero-padded below them
        if (cnt < CW'(SAMPLE_WIDTH)) begin
          if (state == LEFT) begin
            short_chan = 1'b1;
            left_nxt   = left_sr << (CW'(SAMPLE_WIDTH) - cnt);
          end else if (state == RIGHT) begin
            short_chan = 1'b1;
            frame_done = 1'b1;
            right_nxt  = right_sr << (CW'(SAMPLE_WIDTH) - cnt);
          end
        end
        case (state)
          IDLE:    if (!lrck_s) state_nxt = LEFT;
          LEFT:    if (lrck_s)  state_nxt = RIGHT;
          RIGHT:   if (!lrck_s) state_nxt = LEFT;
          default: state_nxt = IDLE;
        endcase
      end else if (state != IDLE && cnt < CW'(SAMPLE_WIDTH)) begin
        cnt_nxt = cnt + 1'b1;
        if (state == LEFT) begin
          left_nxt = {left_sr[SAMPLE_WIDTH-2:0], dat_s};
        end else begin
          right_nxt  = {right_sr[SAMPLE_WIDTH-2:0], dat_s};
          frame_done = cnt == CW'(SAMPLE_WIDTH - 1);
        end
      end
    end
  end

  assign frame_word = {left_nxt, right_nxt};
  assign pop        = adc.adc_valid && adc.adc_ready;

`ifdef ADC_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [WW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          push;

  // When full, a same-cycle pop frees the head slot, which wr_ptr then points at
  assign push     = frame_done && (level != (AW+1)'(FIFO_DEPTH) || pop);
  assign overflow = frame_done && !push;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= frame_word;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign adc.ADCDATA   = mem[rd_ptr];
  assign adc.adc_valid = level != '0;
  assign adc.adc_full  = level == (AW+1)'(FIFO_DEPTH);
`else
  logic [WW-1:0] hold;
  logic          hold_valid;

  assign overflow = frame_done && hold_valid && !pop;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (frame_done && !overflow) begin
      hold       <= frame_word;
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  assign adc.ADCDATA   = hold;
  assign adc.adc_valid = hold_valid;
  assign adc.adc_full  = hold_valid;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      data_over <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      data_over <= (data_over && !clr_err) || overflow;
      frame_err <= (frame_err && !clr_err) || short_chan;
    end
  end
endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Self-checking bench for i2s_adc_receiver: directed scenarios plus randomized frames vs a word-queue model.
module tb_i2s_adc_receiver;
`ifdef ADC_RX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic clk, rst_n, en, bclk, lrck, dat, clr_err, data_over, frame_err;
  logic ready_level, rand_ready;
  int   n_cmp, n_bad;
  logic [31:0] exp_q[$];

  i2s_adc_receiver_if #(.SAMPLE_WIDTH(16)) ifc ();

  i2s_adc_receiver #(
    .SAMPLE_WIDTH(16),
    .SYNC_STAGES (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .Clk        (clk),
    .Reset      (rst_n),
    .EN         (en),
    .AUD_BCLK   (bclk),
    .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT (dat),
    .adc        (ifc),
    .data_over  (data_over),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected channel value: first min(n,16) bits MSB-first, remaining LSBs zero
  function automatic logic [15:0] exp_chan(input logic [15:0] v, input int n);
    logic [15:0] m;
    m = (n >= 16) ? 16'hFFFF : 16'(16'hFFFF << (16 - n));
    return v & m;
  endfunction

  // BCLK period = 8 Clk; LRCK/DAT change while BCLK is low
  task automatic bclk_cycle(input logic lr, input logic d, input bit lat);
    lrck = lr;
    dat  = d;
    repeat (4) tick();
    bclk = 1'b1;
    if (lat) begin
      repeat (2) tick();
      check("lat_early", ifc.adc_valid, 1'b0);
      tick();
      check("lat_valid", ifc.adc_valid, 1'b1);
      tick();
    end else begin
      repeat (4) tick();
    end
    bclk = 1'b0;
  endtask

  task automatic send_channel(input logic lr, input logic [15:0] v, input int n, input bit lat);
    bclk_cycle(lr, 1'($urandom), 1'b0);
    for (int i = 0; i < n; i++)
      bclk_cycle(lr, (i < 16) ? v[15-i] : 1'($urandom), lat && i == 15);
  endtask

  task automatic send_frame(input logic [15:0] l, input int nl, input logic [15:0] r, input int nr,
                            input bit push, input bit lat);
    if (push) exp_q.push_back({exp_chan(l, nl), exp_chan(r, nr)});
    send_channel(1'b0, l, nl, 1'b0);
    send_channel(1'b1, r, nr, lat);
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 3000 && exp_q.size() != 0; c++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  function automatic int pick_len();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return $urandom_range(12, 15);
    if (r < 4) return $urandom_range(17, 19);
    return 16;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ifc.adc_ready = rand_ready ? 1'($urandom % 2) : ready_level;
    end
  end

  // Pops are scored against the model queue; held words must not change
  initial begin
    logic [31:0] prev_data = '0;
    logic        prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ifc.adc_valid) begin
        if (prev_hold) check("stable", ifc.ADCDATA, prev_data);
        if (ifc.adc_ready) begin
          if (exp_q.size() != 0) check("word", ifc.ADCDATA, exp_q.pop_front());
          else check("unexpected_word", ifc.adc_valid, 1'b0);
        end
      end
      prev_hold = rst_n && ifc.adc_valid && !ifc.adc_ready;
      prev_data = ifc.ADCDATA;
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] ov[CAP];
    logic [15:0] v;
    int          nl, nr;
    logic        exp_ferr;
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; en = 1'b0; bclk = 1'b0; lrck = 1'b1; dat = 1'b0; clr_err = 1'b0;
    ready_level = 1'b0; rand_ready = 1'b0; ifc.adc_ready = 1'b0;
    repeat (3) tick();
    check("rst_data", ifc.ADCDATA, 32'h0);
    check("rst_valid", ifc.adc_valid, 1'b0);
    check("rst_full", ifc.adc_full, 1'b0);
    check("rst_over", data_over, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic frame with exact completion latency
    en = 1'b1; ready_level = 1'b1;
    repeat (2) bclk_cycle(1'b1, 1'b0, 1'b0);
    send_frame(16'hA5C3, 16, 16'h3C5A, 16, 1'b1, 1'b1);
    wait_drain();
    check("t1_ferr", frame_err, 1'b0);
    check("t1_over", data_over, 1'b0);

    // EN rising mid-right-channel waits for the next left alignment
    en = 1'b0;
    send_channel(1'b0, 16'h1234, 16, 1'b0);
    send_channel(1'b1, 16'h5678, 5, 1'b0);
    en = 1'b1;
    for (int i = 0; i < 11; i++) bclk_cycle(1'b1, 1'($urandom), 1'b0);
    send_frame(16'hBEEF, 16, 16'hCAFE, 16, 1'b1, 1'b0);
    wait_drain();

    // Overflow with consumer stalled
    ready_level = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < CAP; i++) begin
      ov[i] = (i == 0) ? 32'h11112222 : $urandom;
      send_frame(ov[i][31:16], 16, ov[i][15:0], 16, 1'b0, 1'b0);
    end
    check("t3_full_at_cap", ifc.adc_full, 1'b1);
    check("t3_over_at_cap", data_over, 1'b0);
    send_frame(16'h3333, 16, 16'h4444, 16, 1'b0, 1'b0);
    repeat (2) tick();
    check("t3_head_kept", ifc.ADCDATA, ov[0]);
    check("t3_over_set", data_over, 1'b1);
    check("t3_full", ifc.adc_full, 1'b1);
    pulse_clr();
    check("t3_over_clr", data_over, 1'b0);
    for (int i = 0; i < CAP; i++) exp_q.push_back(ov[i]);
    ready_level = 1'b1;
    wait_drain();
    tick();
    check("t3_empty_valid", ifc.adc_valid, 1'b0);

    // Short left channel: 10 ones padded to FFC0
    send_frame(16'hFFFF, 10, 16'h0F0F, 16, 1'b1, 1'b0);
    wait_drain();
    check("t4_ferr_set", frame_err, 1'b1);
    pulse_clr();
    check("t4_ferr_clr", frame_err, 1'b0);
    send_frame(16'h8001, 16, 16'h7FFE, 16, 1'b1, 1'b0);
    wait_drain();
    check("t4_ferr_after", frame_err, 1'b0);

    // Reset during left bit 7
    v = 16'h9AB7;
    bclk_cycle(1'b1, 1'b0, 1'b0);
    bclk_cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) bclk_cycle(1'b0, v[15-i], 1'b0);
    lrck = 1'b0; dat = v[8];
    repeat (2) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("t5_data", ifc.ADCDATA, 32'h0);
    check("t5_valid", ifc.adc_valid, 1'b0);
    check("t5_full", ifc.adc_full, 1'b0);
    check("t5_over", data_over, 1'b0);
    check("t5_ferr", frame_err, 1'b0);
    rst_n = 1'b1;
    tick();
    for (int i = 7; i < 16; i++) bclk_cycle(1'b0, v[15-i], 1'b0);
    send_channel(1'b1, 16'h2468, 16, 1'b0);
    send_frame(16'h1357, 16, 16'hACE0, 16, 1'b1, 1'b0);
    wait_drain();
    check("t5_ferr_after", frame_err, 1'b0);

    // Randomized frames, random lengths, random ready
    exp_ferr = 1'b0;
    rand_ready = 1'b1;
    for (int f = 0; f < 16; f++) begin
      nl = pick_len();
      nr = pick_len();
      if (nl < 16 || nr < 16) exp_ferr = 1'b1;
      send_frame(16'($urandom), nl, 16'($urandom), nr, 1'b1, 1'b0);
    end
    repeat (2) bclk_cycle(1'b0, 1'($urandom), 1'b0);
    rand_ready = 1'b0;
    ready_level = 1'b1;
    wait_drain();
    check("rand_ferr", frame_err, exp_ferr);
    check("rand_over", data_over, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
